mat_mul_seq: RTL and testbench
==============================

Name: mat_mul_seq

Overview:
- Sequencer directly upstream of the byte-wide data memory.
- Acts as the sole master of that memory's read and write ports.
- Reads the problem header (m, n, l, A base, C base), then computes C = A(m×n) · B(n×l) with one multiply-accumulate at a time.
- Writes each 16-bit result as a little-endian byte pair into the result area.

Parameters:
- DATA_WIDTH, 8, operand byte width; results are 2*DATA_WIDTH.
- ADDR_WIDTH, 8, memory address width; all address arithmetic wraps modulo 2**ADDR_WIDTH.
- HDR_M, 0, header address of m.
- HDR_N, 1, header address of n.
- HDR_L, 2, header address of l.
- HDR_ABASE, 6, header address holding the A base address.
- HDR_CBASE, 7, header address holding the C base address.
- PARK_ADDR, 2**ADDR_WIDTH-2, write address driven whenever the block is not writing.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- start  in  1  sampled in IDLE only; launches one multiply.
- busy  out  1  high from the edge after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse at completion (normal or error).
- err  out  1  set with done when any of m, n, l is 0; held until the next accepted start.
- mem_r_addr  out  ADDR_WIDTH  read address; memory returns data one cycle later.
- mem_r_data  in  DATA_WIDTH  registered read data.
- mem_we  out  1  write strobe.
- mem_w_addr  out  ADDR_WIDTH  low-byte write address; memory writes the high byte at +1.
- mem_w_data  out  2*DATA_WIDTH  result word.

Behaviour:
- Reset values: busy=0, done=0, err=0, mem_we=0, mem_r_addr=0, mem_w_addr=PARK_ADDR, mem_w_data=0; accumulator and all indices 0.
- Memory contract: an address presented in cycle t yields mem_r_data valid in cycle t+1.
- The memory writes the upper byte to w_addr+1 on every clock regardless of we.
  - The block therefore drives mem_w_addr=PARK_ADDR and mem_w_data=0 in every cycle except WR.
  - Bytes PARK_ADDR and PARK_ADDR+1 are reserved scratch.
- States:
  - IDLE: start=1 → HDR. Clear err, i, j, k, acc.
  - HDR (6 cycles): issue reads to HDR_M, HDR_N, HDR_L, HDR_ABASE, HDR_CBASE on cycles 0–4; capture each one cycle later (cycles 1–5). Then go to CHECK.
  - CHECK (1 cycle): compute b_base = a_base + m*n (mod 2**ADDR_WIDTH). If m, n or l is 0 → set err, go to DONE. Otherwise → RD_A.
  - RD_A: mem_r_addr = a_base + i*n + k.
  - RD_B: mem_r_addr = b_base + k*l + j; latch a = mem_r_data.
  - MAC: latch b = mem_r_data; acc += a*b, truncated to 2*DATA_WIDTH (wraps, no saturation). If k = n-1 → WR, otherwise k++ → RD_A.
  - WR (1 cycle):
    - mem_we=1, mem_w_addr = c_base + 2*(i*l + j), mem_w_data = acc.
    - Then clear acc and k, increment j.
    - If j wraps at l, clear j and increment i. If i reaches m → DONE, otherwise → RD_A.
  - DONE (1 cycle): done=1, busy=0 next cycle; → IDLE.
- Latency:
  - Normal run: DONE state begins exactly 7 + m*l*(3n+1) edges after the edge sampling start.
  - Error run: DONE begins after 7 edges, with no writes.
- Write order: row-major C; exactly m*l write cycles per run.
- start while busy: ignored, with no effect on the run in progress.
- start held high through DONE: re-accepted only in IDLE, one cycle later.
- Reset mid-run: outputs return to reset values asynchronously. A partial C may remain in memory; no further writes occur.
- Header values are latched in HDR. Writes into the header or operand area during a run use the latched values for m, n, l and the bases, but the block reads whatever A/B bytes the memory currently holds.
- Address wrap past 2**ADDR_WIDTH-1 is legal and unchecked.

Decomposition:
- Package mm_pkg holds:
  - state encoding localparams: IDLE, HDR, CHECK, RD_A, RD_B, MAC, WR, DONE;
  - header address defaults;
  - cycles-per-element formula constant (3).
- Sub-module mm_mac:
  - holds a, b and acc;
  - inputs load_a, load_b, accumulate, clear;
  - 2*DATA_WIDTH wrapping product-sum.
- Address generation uses running row and column pointers in the top level; no multipliers are needed except the single m*n at CHECK.

Test Plan:
- Header m=2, n=3, l=2, a_base=8, c_base=100; A=1..6 at 8–13; B=7..12 at 14–19.
  - Required: writes (addr, data) = (100, 0x003A), (102, 0x0040), (104, 0x008B), (106, 0x009A), in that order.
  - Required: done at edge 47; err=0.
- m=1, n=1, l=1, A=255, B=255.
  - Required: one write of 0xFE01 to c_base.
  - Required: done at edge 11.
- m=1, n=2, l=1, all operands 255.
  - Required: accumulator wraps; single write of 0xFC02.
- n=0.
  - Required: err=1 with done at edge 7; mem_we never asserted; mem_w_addr stays PARK_ADDR throughout.
- Assert reset for 1 cycle mid-MAC of the first test.
  - Required: busy=0 and mem_we=0 immediately, no further writes.
  - Required: a fresh start then reproduces the full first-test result.
- Pulse start 3 times during a run.
  - Required: result and timing identical to the single-start run.
  - Required: done pulses exactly once.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and constants for the sequential matrix-multiply block.
// The FSM encoding, header address defaults and per-element cycle cost live here.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CHECK,
        RD_A,
        RD_B,
        MAC,
        WR,
        DONE
    } state_t;

    localparam int unsigned DEF_HDR_M     = 0;
    localparam int unsigned DEF_HDR_N     = 1;
    localparam int unsigned DEF_HDR_L     = 2;
    localparam int unsigned DEF_HDR_ABASE = 6;
    localparam int unsigned DEF_HDR_CBASE = 7;

    // Each inner-product term costs RD_A + RD_B + MAC.
    localparam int unsigned CYC_PER_MAC = 3;

endpackage

// File: rtl/mm_mac.sv
// Operand latches and wrapping multiply-accumulator for mat_mul_seq.
// The product uses the incoming B byte directly so latch and accumulate share one cycle.
module mm_mac #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load_a,
    input  logic                      i_load_b,
    input  logic                      i_accumulate,
    input  logic                      i_clear,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic [2*DATA_WIDTH-1:0]   o_acc
);

    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   w_b;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_b    = i_load_b ? i_data : r_b;
    assign w_prod = {{DATA_WIDTH{1'b0}}, r_a} * {{DATA_WIDTH{1'b0}}, w_b};
    assign o_acc  = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            if (i_load_a) r_a <= i_data;
            if (i_load_b) r_b <= i_data;
            if (i_clear)
                r_acc <= '0;
            else if (i_accumulate)
                r_acc <= r_acc + w_prod;
        end
    end

endmodule

// File: rtl/mat_mul_seq.sv
// Memory-mastering sequencer computing C = A(m x n) * B(n x l), one MAC per three cycles.
// Results are written as little-endian 16-bit words; the write port is parked outside WR.
module mat_mul_seq
    import mm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned HDR_M      = DEF_HDR_M,
    parameter int unsigned HDR_N      = DEF_HDR_N,
    parameter int unsigned HDR_L      = DEF_HDR_L,
    parameter int unsigned HDR_ABASE  = DEF_HDR_ABASE,
    parameter int unsigned HDR_CBASE  = DEF_HDR_CBASE,
    parameter int unsigned PARK_ADDR  = 2**ADDR_WIDTH - 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_WIDTH-1:0]     mem_r_addr,
    input  logic [DATA_WIDTH-1:0]     mem_r_data,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_w_addr,
    output logic [2*DATA_WIDTH-1:0]   mem_w_data
);

    localparam logic [DATA_WIDTH-1:0] D_ONE  = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_TWO  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_PARK = ADDR_WIDTH'(PARK_ADDR);

    state_t r_state, w_next;

    logic [2:0]              r_hcnt;
    logic [DATA_WIDTH-1:0]   r_m, r_n, r_l;
    logic [DATA_WIDTH-1:0]   r_i, r_j, r_k;
    logic [ADDR_WIDTH-1:0]   r_abase, r_cbase, r_bbase;
    logic [ADDR_WIDTH-1:0]   r_a_ptr, r_row_a, r_b_ptr, r_col_b, r_c_ptr;
    logic                    r_err;

    logic [ADDR_WIDTH-1:0]   w_n_a, w_l_a, w_bbase;
    logic                    w_zero, w_last_k, w_last_j, w_last_i;
    logic [2*DATA_WIDTH-1:0] w_acc;

    assign w_n_a    = ADDR_WIDTH'(r_n);
    assign w_l_a    = ADDR_WIDTH'(r_l);
    assign w_bbase  = r_abase + ADDR_WIDTH'(r_m) * w_n_a;
    assign w_zero   = (r_m == '0) || (r_n == '0) || (r_l == '0);
    assign w_last_k = (r_k == r_n - D_ONE);
    assign w_last_j = (r_j == r_l - D_ONE);
    assign w_last_i = (r_i == r_m - D_ONE);

    mm_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk          (clk),
        .rst          (reset),
        .i_load_a     (r_state == RD_B),
        .i_load_b     (r_state == MAC),
        .i_accumulate (r_state == MAC),
        .i_clear      (((r_state == IDLE) && start) || (r_state == WR)),
        .i_data       (mem_r_data),
        .o_acc        (w_acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = HDR;
            HDR:     if (r_hcnt == 3'd5) w_next = CHECK;
            CHECK:   w_next = w_zero ? DONE : RD_A;
            RD_A:    w_next = RD_B;
            RD_B:    w_next = MAC;
            MAC:     w_next = w_last_k ? WR : RD_A;
            WR:      w_next = (w_last_j && w_last_i) ? DONE : RD_A;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
        err        = r_err;
        mem_we     = (r_state == WR);
        mem_w_addr = (r_state == WR) ? r_c_ptr : A_PARK;
        mem_w_data = (r_state == WR) ? w_acc : '0;
        mem_r_addr = '0;
        case (r_state)
            HDR: begin
                case (r_hcnt)
                    3'd0:    mem_r_addr = ADDR_WIDTH'(HDR_M);
                    3'd1:    mem_r_addr = ADDR_WIDTH'(HDR_N);
                    3'd2:    mem_r_addr = ADDR_WIDTH'(HDR_L);
                    3'd3:    mem_r_addr = ADDR_WIDTH'(HDR_ABASE);
                    3'd4:    mem_r_addr = ADDR_WIDTH'(HDR_CBASE);
                    default: mem_r_addr = '0;
                endcase
            end
            RD_A:    mem_r_addr = r_a_ptr;
            RD_B:    mem_r_addr = r_b_ptr;
            default: mem_r_addr = '0;
        endcase
    end

    // Running pointers replace a_base+i*n+k, b_base+k*l+j and c_base+2*(i*l+j).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt  <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_l     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_abase <= '0;
            r_cbase <= '0;
            r_bbase <= '0;
            r_a_ptr <= '0;
            r_row_a <= '0;
            r_b_ptr <= '0;
            r_col_b <= '0;
            r_c_ptr <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_err  <= 1'b0;
                        r_hcnt <= '0;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_k    <= '0;
                    end
                end
                HDR: begin
                    r_hcnt <= r_hcnt + 3'd1;
                    case (r_hcnt)
                        3'd1:    r_m     <= mem_r_data;
                        3'd2:    r_n     <= mem_r_data;
                        3'd3:    r_l     <= mem_r_data;
                        3'd4:    r_abase <= ADDR_WIDTH'(mem_r_data);
                        3'd5:    r_cbase <= ADDR_WIDTH'(mem_r_data);
                        default: ;
                    endcase
                end
                CHECK: begin
                    if (w_zero) r_err <= 1'b1;
                    r_bbase <= w_bbase;
                    r_a_ptr <= r_abase;
                    r_row_a <= r_abase;
                    r_b_ptr <= w_bbase;
                    r_col_b <= w_bbase;
                    r_c_ptr <= r_cbase;
                end
                MAC: begin
                    if (!w_last_k) begin
                        r_k     <= r_k + D_ONE;
                        r_a_ptr <= r_a_ptr + A_ONE;
                        r_b_ptr <= r_b_ptr + w_l_a;
                    end
                end
                WR: begin
                    r_k     <= '0;
                    r_c_ptr <= r_c_ptr + A_TWO;
                    if (w_last_j) begin
                        r_j     <= '0;
                        r_i     <= r_i + D_ONE;
                        r_row_a <= r_row_a + w_n_a;
                        r_a_ptr <= r_row_a + w_n_a;
                        r_b_ptr <= r_bbase;
                        r_col_b <= r_bbase;
                    end else begin
                        r_j     <= r_j + D_ONE;
                        r_a_ptr <= r_row_a;
                        r_b_ptr <= r_col_b + A_ONE;
                        r_col_b <= r_col_b + A_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Self-checking bench for mat_mul_seq: byte memory model, matrix-level reference
// model producing per-cycle expectations, and literal checks of known results.
module tb_mat_mul_seq;

    localparam logic [7:0] PARK = 8'd254;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err, mem_we;
    logic [7:0]  mem_r_addr, mem_w_addr;
    logic [7:0]  mem_r_data;
    logic [15:0] mem_w_data;

    mat_mul_seq #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;

    always @(posedge clk) begin
        mem_r_data <= mem[mem_r_addr];
        if (ld_en) mem[ld_addr] <= ld_data;
        if (mem_we) mem[mem_w_addr] <= mem_w_data[7:0];
        mem[mem_w_addr + 8'd1] <= mem_w_data[15:8];
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model state
    bit          armed = 1'b0;
    int          t0 = 0;
    int          t_done = 0;
    bit          exp_err_run = 1'b0;
    int          wr_rel[$];
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          n_done = 0;
    int          n_wr = 0;
    int          done_rel = -1;

    task automatic arm_model();
        int m, n, l;
        logic [7:0]  ab, cb, bb;
        logic [15:0] acc;
        int e;
        m  = int'(mem[0]);
        n  = int'(mem[1]);
        l  = int'(mem[2]);
        ab = mem[6];
        cb = mem[7];
        bb = ab + 8'(m * n);
        wr_rel.delete();
        wr_addr.delete();
        wr_data.delete();
        if (m == 0 || n == 0 || l == 0) begin
            exp_err_run = 1'b1;
            t_done      = 7;
        end else begin
            exp_err_run = 1'b0;
            t_done      = 7 + m * l * (mm_pkg::CYC_PER_MAC * n + 1);
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < l; j++) begin
                    acc = 16'd0;
                    for (int k = 0; k < n; k++)
                        acc = acc + {8'd0, mem[8'(ab + 8'(i * n + k))]} * {8'd0, mem[8'(bb + 8'(k * l + j))]};
                    e = i * l + j;
                    wr_rel.push_back(7 + e * (mm_pkg::CYC_PER_MAC * n + 1) + mm_pkg::CYC_PER_MAC * n);
                    wr_addr.push_back(cb + 8'(2 * e));
                    wr_data.push_back(acc);
                end
            end
        end
        n_done   = 0;
        n_wr     = 0;
        done_rel = -1;
    endtask

    always @(negedge clk) begin
        int          rel;
        logic        e_busy, e_done, e_we, e_err;
        logic [7:0]  e_addr;
        logic [15:0] e_data;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_we   = 1'b0;
        e_err  = 1'b0;
        e_addr = PARK;
        e_data = 16'd0;
        rel    = -1;
        if (armed) begin
            rel    = edge_n - t0;
            e_busy = (rel >= 0) && (rel <= t_done);
            e_done = (rel == t_done);
            e_err  = exp_err_run && (rel >= t_done);
            foreach (wr_rel[q]) begin
                if (wr_rel[q] == rel) begin
                    e_we   = 1'b1;
                    e_addr = wr_addr[q];
                    e_data = wr_data[q];
                end
            end
        end
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("mem_we", mem_we, e_we);
        chk("mem_w_addr", mem_w_addr, e_addr);
        chk("mem_w_data", mem_w_data, e_data);
        if (done) begin
            n_done++;
            done_rel = rel;
        end
        if (mem_we) n_wr++;
    end

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic set_hdr(input logic [7:0] m, input logic [7:0] n, input logic [7:0] l,
                           input logic [7:0] ab, input logic [7:0] cb);
        load(8'd0, m);
        load(8'd1, n);
        load(8'd2, l);
        load(8'd6, ab);
        load(8'd7, cb);
    endtask

    task automatic run(input string tag, input bit extra_starts);
        int r;
        @(negedge clk);
        #1;
        arm_model();
        t0    = edge_n + 1;
        armed = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 3000 && n_done == 0; c++) begin
            @(negedge clk);
            #1;
            r     = edge_n - t0;
            start = extra_starts && (r == 5 || r == 20 || r == 30);
        end
        start = 1'b0;
        if (n_done == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_done_count"}, n_done, 1);
        chk({tag, "_write_count"}, n_wr, wr_rel.size());
    endtask

    task automatic setup_t1();
        set_hdr(8'd2, 8'd3, 8'd2, 8'd8, 8'd100);
        for (int i = 0; i < 12; i++) load(8'(8 + i), 8'(1 + i));
        for (int i = 0; i < 8; i++) load(8'(100 + i), 8'd0);
    endtask

    task automatic check_t1(input string tag);
        logic [7:0] exp_c [8];
        exp_c = '{8'h3A, 8'h00, 8'h40, 8'h00, 8'h8B, 8'h00, 8'h9A, 8'h00};
        chk({tag, "_done_edge"}, done_rel, 47);
        chk({tag, "_err"}, err, 1'b0);
        for (int i = 0; i < 8; i++) chk({tag, "_mem_c"}, mem[100 + i], exp_c[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_r_addr", mem_r_addr, 8'd0);
        chk("rst_w_addr", mem_w_addr, PARK);
        chk("rst_w_data", mem_w_data, 16'd0);
        reset = 1'b0;

        // Test 1: 2x3 * 3x2
        setup_t1();
        run("t1", 1'b0);
        check_t1("t1");
        chk("model_t1_c00", wr_data[0], 16'h003A);
        chk("model_t1_c11", wr_data[3], 16'h009A);
        chk("model_t1_addr3", wr_addr[3], 8'd106);

        // Extra start pulses while busy must be ignored
        for (int i = 0; i < 8; i++) load(8'(100 + i), 8'd0);
        run("t1_multistart", 1'b1);
        check_t1("t1_multistart");

        // Reset mid-MAC, then a full rerun
        for (int i = 0; i < 8; i++) load(8'(100 + i), 8'd0);
        @(negedge clk);
        #1;
        arm_model();
        t0    = edge_n + 1;
        armed = 1'b1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        reset = 1'b1;
        armed = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_we", mem_we, 1'b0);
        chk("midrst_r_addr", mem_r_addr, 8'd0);
        chk("midrst_w_addr", mem_w_addr, PARK);
        @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("midrst_no_writes", n_wr, 0);
        chk("midrst_c_untouched", mem[100], 8'h00);
        run("t1_after_rst", 1'b0);
        check_t1("t1_after_rst");

        // Test 2: 1x1 with 255*255
        set_hdr(8'd1, 8'd1, 8'd1, 8'd40, 8'd60);
        load(8'd40, 8'd255);
        load(8'd41, 8'd255);
        load(8'd60, 8'd0);
        load(8'd61, 8'd0);
        run("t2", 1'b0);
        chk("t2_done_edge", done_rel, 11);
        chk("model_t2", wr_data[0], 16'hFE01);
        chk("t2_mem_lo", mem[60], 8'h01);
        chk("t2_mem_hi", mem[61], 8'hFE);

        // Test 3: accumulator wraps
        set_hdr(8'd1, 8'd2, 8'd1, 8'd40, 8'd60);
        for (int i = 0; i < 4; i++) load(8'(40 + i), 8'd255);
        load(8'd60, 8'd0);
        load(8'd61, 8'd0);
        run("t3", 1'b0);
        chk("t3_done_edge", done_rel, 7 + 7);
        chk("model_t3", wr_data[0], 16'hFC02);
        chk("t3_mem_lo", mem[60], 8'h02);
        chk("t3_mem_hi", mem[61], 8'hFC);

        // Test 4: n = 0 is an error with no writes
        set_hdr(8'd2, 8'd0, 8'd2, 8'd8, 8'd100);
        run("t4", 1'b0);
        chk("t4_done_edge", done_rel, 7);
        chk("t4_err_held", err, 1'b1);
        chk("t4_no_writes", n_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
